// File: rtl/noc_local_arbiter.sv
// Packet-atomic round-robin arbiter that merges N_REQ AXI-Stream requesters onto the local
// injection port. Define NOC_ARB_PKTCNT_EN to add per-requester saturating packet counters.
module noc_local_arbiter #(
  parameter int unsigned BW    = 32,
  parameter int unsigned BWB   = BW / 8,
  parameter int unsigned N_REQ = 2
) (
  input  logic                 clk_line,
  input  logic                 clk_line_rst_high,
  input  logic [N_REQ-1:0]     s_TVALID,
  input  logic [N_REQ-1:0]     s_TLAST,
  output logic [N_REQ-1:0]     s_TREADY,
  input  logic [N_REQ*BW-1:0]  s_TDATA,
  input  logic [N_REQ*BWB-1:0] s_TKEEP,
  output logic                 m_TVALID,
  input  logic                 m_TREADY,
  output logic [BW-1:0]        m_TDATA,
  output logic [BWB-1:0]       m_TKEEP,
  output logic                 m_TLAST,
  output logic [N_REQ-1:0]     grant,
  output logic                 busy
`ifdef NOC_ARB_PKTCNT_EN
  ,
  output logic [N_REQ*16-1:0]  pkt_cnt
`endif
);

  localparam int unsigned IW = $clog2(N_REQ);

  localparam logic [0:0] StIdle = 1'b0;
  localparam logic [0:0] StLock = 1'b1;

  logic [0:0]       state_q, state_d;
  logic [N_REQ-1:0] grant_q, grant_d;
  logic [IW-1:0]    ptr_q, ptr_d;
  logic [IW-1:0]    pick_idx, gidx;
  logic             last_xfer;

  // Round-robin pick: lowest valid index above the pointer wins, else lowest valid at or below.
  always_comb begin
    logic          hi_found;
    logic [IW-1:0] hi_idx, lo_idx;
    hi_found = 1'b0;
    hi_idx   = '0;
    lo_idx   = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (s_TVALID[i]) begin
        if (i > int'(ptr_q)) begin
          hi_found = 1'b1;
          hi_idx   = IW'(i);
        end else begin
          lo_idx = IW'(i);
        end
      end
    end
    pick_idx = hi_found ? hi_idx : lo_idx;
  end

  always_comb begin
    gidx = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant_q[i]) gidx = IW'(i);
    end
  end

  // grant_q is all-zero while idle, so the output mux is naturally quiet outside a lock.
  always_comb begin
    m_TDATA = '0;
    m_TKEEP = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant_q[i]) begin
        m_TDATA = s_TDATA[i*BW +: BW];
        m_TKEEP = s_TKEEP[i*BWB +: BWB];
      end
    end
  end

  assign m_TVALID  = |(grant_q & s_TVALID);
  assign m_TLAST   = |(grant_q & s_TLAST);
  assign s_TREADY  = grant_q & {N_REQ{m_TREADY}};
  assign last_xfer = m_TVALID & m_TREADY & m_TLAST;
  assign grant     = grant_q;
  assign busy      = (state_q == StLock);

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    ptr_d   = ptr_q;
    case (state_q)
      StIdle: begin
        if (|s_TVALID) begin
          state_d           = StLock;
          grant_d           = '0;
          grant_d[pick_idx] = 1'b1;
        end
      end
      StLock: begin
        if (last_xfer) begin
          state_d = StIdle;
          grant_d = '0;
          ptr_d   = gidx;
        end
      end
      default: begin
        state_d = StIdle;
        grant_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk_line or posedge clk_line_rst_high) begin
    if (clk_line_rst_high) begin
      state_q <= StIdle;
      grant_q <= '0;
      ptr_q   <= IW'(N_REQ - 1);
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      ptr_q   <= ptr_d;
    end
  end

`ifdef NOC_ARB_PKTCNT_EN
  logic [N_REQ-1:0][15:0] cnt_q;

  always_ff @(posedge clk_line or posedge clk_line_rst_high) begin
    if (clk_line_rst_high) begin
      cnt_q <= '0;
    end else if (last_xfer && (cnt_q[gidx] != 16'hFFFF)) begin
      cnt_q[gidx] <= cnt_q[gidx] + 16'd1;
    end
  end

  assign pkt_cnt = cnt_q;
`else
  // Packet counters are compiled out in the default build.
`endif

endmodule

// File: tb/tb_noc_local_arbiter.sv
// Scoreboard bench for noc_local_arbiter: a 4-requester instance for most scenarios and a
// 2-requester instance for continuous alternation.
module tb_noc_local_arbiter;
  localparam int BW    = 32;
  localparam int BWB   = 4;
  localparam int NR    = 4;
  localparam int DEPTH = 64;

  typedef struct packed {
    logic           gap;
    logic [BW-1:0]  data;
    logic [BWB-1:0] keep;
    logic           last;
  } beat_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [NR-1:0]     s_TVALID, s_TLAST, s_TREADY;
  logic [NR*BW-1:0]  s_TDATA;
  logic [NR*BWB-1:0] s_TKEEP;
  logic              m_TVALID, m_TREADY, m_TLAST;
  logic [BW-1:0]     m_TDATA;
  logic [BWB-1:0]    m_TKEEP;
  logic [NR-1:0]     grant;
  logic              busy;

  logic [1:0]       s2_TVALID, s2_TLAST, s2_TREADY;
  logic [2*BW-1:0]  s2_TDATA;
  logic [2*BWB-1:0] s2_TKEEP;
  logic             m2_TVALID, m2_TLAST;
  logic             m2_TREADY = 1'b1;
  logic [BW-1:0]    m2_TDATA;
  logic [BWB-1:0]   m2_TKEEP;
  logic [1:0]       grant2;
  logic             busy2;
`ifdef NOC_ARB_PKTCNT_EN
  logic [NR*16-1:0] pkt_cnt;
  logic [31:0]      pkt_cnt2;
`endif

  noc_local_arbiter #(.BW(BW), .BWB(BWB), .N_REQ(NR)) dut (
    .clk_line          (clk),
    .clk_line_rst_high (rst),
    .s_TVALID          (s_TVALID),
    .s_TLAST           (s_TLAST),
    .s_TREADY          (s_TREADY),
    .s_TDATA           (s_TDATA),
    .s_TKEEP           (s_TKEEP),
    .m_TVALID          (m_TVALID),
    .m_TREADY          (m_TREADY),
    .m_TDATA           (m_TDATA),
    .m_TKEEP           (m_TKEEP),
    .m_TLAST           (m_TLAST),
    .grant             (grant),
    .busy              (busy)
`ifdef NOC_ARB_PKTCNT_EN
    ,
    .pkt_cnt           (pkt_cnt)
`endif
  );

  noc_local_arbiter #(.BW(BW), .BWB(BWB), .N_REQ(2)) dut2 (
    .clk_line          (clk),
    .clk_line_rst_high (rst),
    .s_TVALID          (s2_TVALID),
    .s_TLAST           (s2_TLAST),
    .s_TREADY          (s2_TREADY),
    .s_TDATA           (s2_TDATA),
    .s_TKEEP           (s2_TKEEP),
    .m_TVALID          (m2_TVALID),
    .m_TREADY          (m2_TREADY),
    .m_TDATA           (m2_TDATA),
    .m_TKEEP           (m2_TKEEP),
    .m_TLAST           (m2_TLAST),
    .grant             (grant2),
    .busy              (busy2)
`ifdef NOC_ARB_PKTCNT_EN
    ,
    .pkt_cnt           (pkt_cnt2)
`endif
  );

  beat_t src_mem [NR][DEPTH];
  int    src_wr [NR];
  int    src_rd [NR];
  int    exp_rd [NR];
  int    glog[$], gaps[$], glog2[$], gaps2[$];
  int    n_tests = 0, n_fail = 0;
  int    cyc = 0, last_end = 0, last_end2 = 0, beats_seen = 0, beats2 = 0;
  int    stall_cnt = 0, r0_ready_cnt = 0;
  int    bc2 [2];
  bit    in_pkt = 0, in_pkt2 = 0, tready_toggle = 0, en2 = 0;
  logic [NR-1:0] xfer;
  logic [1:0]    xfer2;

  task automatic push_beat(input int s, input beat_t b);
    src_mem[s][src_wr[s]] = b;
    src_wr[s]++;
  endtask

  // Beat k carries {tag, source, k}; gap_len idle cycles are inserted after beat gap_after.
  task automatic push_pkt(input int s, input int n, input logic [7:0] tag,
                          input int gap_after, input int gap_len);
    beat_t b;
    for (int k = 0; k < n; k++) begin
      b.gap  = 1'b0;
      b.data = {tag, 8'(s), 16'(k)};
      b.keep = BWB'(k + 2 * s + 1);
      b.last = (k == n - 1);
      push_beat(s, b);
      if (k == gap_after) begin
        for (int j = 0; j < gap_len; j++) begin
          b     = '0;
          b.gap = 1'b1;
          push_beat(s, b);
        end
      end
    end
  endtask

  task automatic flush_srcs();
    for (int i = 0; i < NR; i++) begin
      src_wr[i] = 0;
      src_rd[i] = 0;
      exp_rd[i] = 0;
    end
    in_pkt = 0;
  endtask

  task automatic drive_srcs();
    for (int i = 0; i < NR; i++) begin
      if (src_rd[i] < src_wr[i] && !src_mem[i][src_rd[i]].gap) begin
        s_TVALID[i]              = 1'b1;
        s_TLAST[i]               = src_mem[i][src_rd[i]].last;
        s_TDATA[i*BW +: BW]      = src_mem[i][src_rd[i]].data;
        s_TKEEP[i*BWB +: BWB]    = src_mem[i][src_rd[i]].keep;
      end else begin
        s_TVALID[i]              = 1'b0;
        s_TLAST[i]               = 1'b0;
        s_TDATA[i*BW +: BW]      = '0;
        s_TKEEP[i*BWB +: BWB]    = '0;
      end
    end
    for (int i = 0; i < 2; i++) begin
      s2_TVALID[i]           = en2;
      s2_TLAST[i]            = (bc2[i] % 3 == 2);
      s2_TDATA[i*BW +: BW]   = {8'hA0, 8'(i), 16'(bc2[i])};
      s2_TKEEP[i*BWB +: BWB] = BWB'(bc2[i] + 1);
    end
  endtask

  task automatic monitor();
    int    g;
    beat_t e;
    xfer  = s_TVALID & s_TREADY;
    xfer2 = s2_TVALID & s2_TREADY;
    n_tests++;
    if (s_TREADY !== (grant & {NR{m_TREADY}}) || !$onehot0(grant) || busy !== (|grant)) begin
      n_fail++;
      $display("FAIL ready_grant: s_TREADY=%b grant=%b busy=%b m_TREADY=%b",
               s_TREADY, grant, busy, m_TREADY);
    end
    if (s_TREADY[0]) r0_ready_cnt++;
    if (grant == 4'b0001 && !m_TVALID) stall_cnt++;
    if (m_TVALID && m_TREADY) begin
      g = -1;
      for (int i = 0; i < NR; i++) if (grant[i]) g = i;
      n_tests++;
      if (g < 0) begin
        n_fail++;
        $display("FAIL beat_owner: beat with grant=%b, required one-hot", grant);
      end else begin
        while (exp_rd[g] < src_wr[g] && src_mem[g][exp_rd[g]].gap) exp_rd[g]++;
        if (exp_rd[g] >= src_wr[g]) begin
          n_fail++;
          $display("FAIL beat_extra: req %0d data %h, required no beat", g, m_TDATA);
        end else begin
          e = src_mem[g][exp_rd[g]];
          exp_rd[g]++;
          if ({m_TDATA, m_TKEEP, m_TLAST} !== {e.data, e.keep, e.last}) begin
            n_fail++;
            $display("FAIL beat_data: req %0d got %h/%h/%b required %h/%h/%b", g,
                     m_TDATA, m_TKEEP, m_TLAST, e.data, e.keep, e.last);
          end
        end
        if (!in_pkt) begin
          glog.push_back(g);
          gaps.push_back(cyc - last_end);
          in_pkt = 1;
        end
        beats_seen++;
        if (m_TLAST) begin
          in_pkt   = 0;
          last_end = cyc;
        end
      end
    end
    if (m2_TVALID) begin
      g = grant2[1] ? 1 : 0;
      n_tests++;
      if ({m2_TDATA, m2_TKEEP, m2_TLAST} !==
          {8'hA0, 8'(g), 16'(bc2[g]), BWB'(bc2[g] + 1), (bc2[g] % 3 == 2)} || grant2 == 2'b00) begin
        n_fail++;
        $display("FAIL two_req_beat: grant=%b got %h/%b required beat %0d of req %0d",
                 grant2, m2_TDATA, m2_TLAST, bc2[g], g);
      end
      if (!in_pkt2) begin
        glog2.push_back(g);
        gaps2.push_back(cyc - last_end2);
        in_pkt2 = 1;
      end
      beats2++;
      if (m2_TLAST) begin
        in_pkt2   = 0;
        last_end2 = cyc;
      end
    end
  endtask

  // Monitor on the falling edge, advance and drive sources just after the rising edge.
  task automatic step();
    @(negedge clk);
    cyc++;
    monitor();
    @(posedge clk);
    #1;
    for (int i = 0; i < NR; i++) begin
      if (src_rd[i] < src_wr[i] && (src_mem[i][src_rd[i]].gap || xfer[i])) src_rd[i]++;
    end
    for (int i = 0; i < 2; i++) if (xfer2[i]) bc2[i]++;
    m_TREADY = tready_toggle ? ~m_TREADY : 1'b1;
    drive_srcs();
  endtask

  function automatic bit drained();
    for (int i = 0; i < NR; i++) if (exp_rd[i] < src_wr[i]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic wait_drain(input int budget, input string name);
    int k = 0;
    while (!drained() && k < budget) begin
      step();
      k++;
    end
    n_tests++;
    if (!drained()) begin
      n_fail++;
      $display("FAIL %s_drain: beats outstanding after %0d cycles, required none", name, budget);
      flush_srcs();
      drive_srcs();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    m_TREADY = 1'b1;
    s_TVALID = '1;
    s_TLAST  = '1;
    s_TDATA  = '1;
    s_TKEEP  = '1;
    s2_TVALID = '1;
    #2;
    n_tests++;
    if (grant !== '0 || busy !== 1'b0 || m_TVALID !== 1'b0 || s_TREADY !== '0 ||
        grant2 !== '0 || busy2 !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: grant=%b busy=%b m_TVALID=%b s_TREADY=%b, required zeros",
               grant, busy, m_TVALID, s_TREADY);
    end
    repeat (2) @(posedge clk);
    #1;
    n_tests++;
    if (grant !== '0 || busy !== 1'b0 || m_TVALID !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_held: grant=%b busy=%b after edges in reset, required 0", grant, busy);
    end
    flush_srcs();
    en2 = 0;
    drive_srcs();
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    n_tests++;
    if (grant !== '0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_idle: grant=%b busy=%b with no requests, required 0", grant, busy);
    end
  endtask

  task automatic test_two_req();
    int k = 0;
    int exp_g [4] = '{0, 1, 0, 1};
    bc2[0] = 0;
    bc2[1] = 0;
    beats2 = 0;
    glog2.delete();
    gaps2.delete();
    en2 = 1;
    drive_srcs();
    while (beats2 < 12 && k < 80) begin
      step();
      k++;
    end
    en2 = 0;
    drive_srcs();
    n_tests++;
    if (glog2.size() != 4) begin
      n_fail++;
      $display("FAIL two_req_count: %0d packets, required 4", glog2.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        n_tests++;
        if (glog2[i] != exp_g[i] || (i > 0 && gaps2[i] != 2)) begin
          n_fail++;
          $display("FAIL two_req_grant: pkt %0d owner %0d gap %0d, required %0d gap 2",
                   i, glog2[i], gaps2[i], exp_g[i]);
        end
      end
    end
  endtask

  task automatic test_alternate();
    int exp_g [4] = '{0, 1, 0, 1};
    glog.delete();
    gaps.delete();
    push_pkt(0, 3, 8'h10, -1, 0);
    push_pkt(1, 3, 8'h11, -1, 0);
    push_pkt(0, 3, 8'h12, -1, 0);
    push_pkt(1, 3, 8'h13, -1, 0);
    drive_srcs();
    #1;
    n_tests++;
    if (m_TVALID !== 1'b0 || s_TREADY !== '0 || grant !== '0) begin
      n_fail++;
      $display("FAIL idle_quiet: m_TVALID=%b s_TREADY=%b grant=%b, required 0 in idle",
               m_TVALID, s_TREADY, grant);
    end
    step();
    n_tests++;
    if (grant !== 4'b0001 || busy !== 1'b1 || m_TVALID !== 1'b1) begin
      n_fail++;
      $display("FAIL first_grant: grant=%b busy=%b, required 0001/1", grant, busy);
    end
    wait_drain(80, "alternate");
    n_tests++;
    if (glog.size() != 4) begin
      n_fail++;
      $display("FAIL alternate_count: %0d packets, required 4", glog.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        n_tests++;
        if (glog[i] != exp_g[i] || (i > 0 && gaps[i] != 2)) begin
          n_fail++;
          $display("FAIL alternate_grant: pkt %0d owner %0d gap %0d, required %0d gap 2",
                   i, glog[i], gaps[i], exp_g[i]);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    int base = beats_seen;
    r0_ready_cnt = 0;
    push_pkt(1, 4, 8'h20, -1, 0);
    tready_toggle = 1;
    drive_srcs();
    wait_drain(60, "backpressure");
    tready_toggle = 0;
    n_tests++;
    if (beats_seen - base != 4 || r0_ready_cnt != 0) begin
      n_fail++;
      $display("FAIL backpressure: %0d beats, s_TREADY[0] high %0d cycles, required 4 and 0",
               beats_seen - base, r0_ready_cnt);
    end
  endtask

  task automatic test_drop_valid();
    glog.delete();
    gaps.delete();
    stall_cnt = 0;
    push_pkt(0, 4, 8'h30, 1, 3);
    push_pkt(1, 2, 8'h31, -1, 0);
    drive_srcs();
    wait_drain(60, "drop_valid");
    n_tests++;
    if (glog.size() != 2 || glog[0] != 0 || glog[1] != 1 || stall_cnt != 3) begin
      n_fail++;
      $display("FAIL drop_valid: %0d pkts first %0d, stall %0d, required 2 pkts 0 then 1, stall 3",
               glog.size(), glog.size() > 0 ? glog[0] : -1, stall_cnt);
    end
  endtask

  task automatic test_reset_mid();
    int base = beats_seen;
    int k = 0;
    push_pkt(0, 1, 8'h40, -1, 0);
    push_pkt(0, 5, 8'h41, -1, 0);
    drive_srcs();
    while (beats_seen < base + 3 && k < 40) begin
      step();
      k++;
    end
    #2;
    rst = 1'b1;
    #1;
    n_tests++;
    if (m_TVALID !== 1'b0 || busy !== 1'b0 || grant !== '0 || s_TREADY !== '0) begin
      n_fail++;
      $display("FAIL async_reset: m_TVALID=%b busy=%b grant=%b, required 0 before any edge",
               m_TVALID, busy, grant);
    end
    flush_srcs();
    drive_srcs();
    step();
    step();
    rst = 1'b0;
    glog.delete();
    gaps.delete();
    push_pkt(0, 2, 8'h42, -1, 0);
    push_pkt(1, 2, 8'h43, -1, 0);
    drive_srcs();
    wait_drain(40, "reset_mid");
    n_tests++;
    if (glog.size() != 2 || glog[0] != 0 || glog[1] != 1) begin
      n_fail++;
      $display("FAIL reset_resume: %0d pkts first owner %0d, required 2 pkts owner 0 first",
               glog.size(), glog.size() > 0 ? glog[0] : -1);
    end
  endtask

  task automatic test_single_beat();
    int exp_g [8] = '{0, 1, 2, 3, 0, 1, 2, 3};
    rst = 1'b1;
    #1;
    rst = 1'b0;
    flush_srcs();
    glog.delete();
    gaps.delete();
    for (int r = 0; r < 2; r++) begin
      for (int s = 0; s < NR; s++) push_pkt(s, 1, 8'(8'h50 + r), -1, 0);
    end
    drive_srcs();
    wait_drain(60, "single_beat");
    n_tests++;
    if (glog.size() != 8) begin
      n_fail++;
      $display("FAIL single_count: %0d packets, required 8", glog.size());
    end else begin
      for (int i = 0; i < 8; i++) begin
        n_tests++;
        if (glog[i] != exp_g[i] || (i > 0 && gaps[i] != 2)) begin
          n_fail++;
          $display("FAIL single_grant: pkt %0d owner %0d gap %0d, required %0d gap 2",
                   i, glog[i], gaps[i], exp_g[i]);
        end
      end
    end
`ifdef NOC_ARB_PKTCNT_EN
    for (int i = 0; i < NR; i++) begin
      n_tests++;
      if (pkt_cnt[i*16 +: 16] !== 16'd2) begin
        n_fail++;
        $display("FAIL pkt_cnt: slice %0d = %0d, required 2", i, pkt_cnt[i*16 +: 16]);
      end
    end
`endif
  endtask

  initial begin
    test_reset();
    test_two_req();
    test_alternate();
    test_backpressure();
    test_drop_valid();
    test_reset_mid();
    test_single_beat();
    step();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/noc_local_arbiter.md
NOC_LOCAL_ARBITER -- requirements
Module: noc_local_arbiter

Interface
REQ-001 Parameter BW, default 32, stream data width in bits.
REQ-002 Parameter BWB, default BW/8, TKEEP width per stream.
REQ-003 Parameter N_REQ, default 2, number of requesters sharing the tile local injection port; legal range 2..4.
REQ-004 Port clk_line  input  1  line clock; the only clock.
REQ-005 Port clk_line_rst_high  input  1  reset, asynchronous, active-high.
REQ-006 Ports s_TVALID / s_TLAST  input  N_REQ  per-requester valid / last; s_TREADY  output  N_REQ  per-requester ready.
REQ-007 Ports s_TDATA  input  N_REQ*BW and s_TKEEP  input  N_REQ*BWB, requester i in slice i.
REQ-008 Ports m_TVALID  output  1, m_TREADY  input  1, m_TDATA  output  BW, m_TKEEP  output  BWB, m_TLAST  output  1; connect to the switch local-in port.
REQ-009 Port grant  output  N_REQ  one-hot owner of the port, all-zero when idle.
REQ-010 Port busy  output  1  high while a packet is locked.

Function
REQ-011 Two states: IDLE, LOCK; state, grant and the round-robin pointer are registered.
REQ-012 In IDLE, all s_TREADY SHALL be 0 and m_TVALID 0; no beat transfers.
REQ-013 In IDLE with any s_TVALID high, the arbiter picks the first requester with s_TVALID high, searching from pointer+1 upward modulo N_REQ, and enters LOCK next cycle with grant set to it.
REQ-014 In LOCK, m_TVALID/m_TDATA/m_TKEEP/m_TLAST SHALL equal the granted requester's signals combinationally, s_TREADY[g] = m_TREADY, all other s_TREADY = 0.
REQ-015 A beat transfers when m_TVALID and m_TREADY are both high; zero added latency on data in LOCK.
REQ-016 On a transferring beat with m_TLAST = 1, the next state is IDLE, pointer := granted index, and grant clears.
REQ-017 Grant is packet-atomic: a granted requester dropping s_TVALID mid-packet keeps the lock; m_TVALID follows it low.
REQ-018 Exactly one idle (arbitration) cycle separates consecutive packets, including single-beat packets.
REQ-019 Requests arriving during LOCK wait; no requester is starved: with all requesters continuously valid, grants rotate 0,1,..,N_REQ-1,0.
REQ-020 Data/keep are not inspected or modified; TKEEP passes through unchanged.

Reset
REQ-021 While clk_line_rst_high is high: state IDLE, grant 0, busy 0, m_TVALID 0, all s_TREADY 0, pointer N_REQ-1 (requester 0 has first priority).
REQ-022 Reset asserted mid-packet SHALL drop the lock immediately (asynchronously); the partial packet is abandoned and is not resumed after reset.

Configuration
REQ-023 Macro NOC_ARB_PKTCNT_EN: when defined, adds output pkt_cnt (N_REQ*16 bits), per-requester 16-bit counters incremented on each transferred TLAST beat of that requester, saturating at 0xFFFF, reset to 0.
REQ-024 Without NOC_ARB_PKTCNT_EN, the pkt_cnt port and counters SHALL not exist; all other behaviour is identical.

Verification
REQ-025 Reset, then s_TVALID=2'b11 continuous, 3-beat packets, m_TREADY=1 -> grants alternate 0,1,0,1; one idle cycle between packets; m_TLAST on every third beat.
REQ-026 Requester 1 sends 4-beat packet; m_TREADY toggles 1,0,1,0 -> exactly 4 beats delivered, data order preserved, s_TREADY[0] stays 0 throughout.
REQ-027 Requester 0 locked, deasserts s_TVALID for 3 cycles after beat 2 while requester 1 is valid -> grant stays 2'b01, m_TVALID low 3 cycles, packet completes before requester 1 granted.
REQ-028 Assert reset after beat 2 of a 5-beat packet -> m_TVALID, busy, grant go 0 without a clock edge; after release with both valid, requester 0 granted first.
REQ-029 Single-beat packets (TLAST on every beat) from N_REQ=4 all valid -> grant sequence 0,1,2,3,0, one beat per two cycles.
REQ-030 With NOC_ARB_PKTCNT_EN, 70000 single-beat packets from requester 0 -> pkt_cnt slice 0 = 0xFFFF, slice 1 = 0.
